// File: rtl/vga_framebuffer.sv
// Pixel store behind the vga pixel-request interface: registered read port,
// handshaked single-pixel writes, and a fill engine that paints the active area.
module vga_framebuffer #(
  parameter int unsigned BUF_WIDTH  = 640,
  parameter int unsigned BUF_HEIGHT = 480,
  parameter bit          TEAR_FREE  = 1'b0
) (
  input  logic        clk,
  input  logic        srst,
  input  logic [9:0]  width,
  input  logic [9:0]  height,
  input  logic [19:0] req_addr,
  output logic [2:0]  pixel,
  input  logic        visible,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [9:0]  wr_x,
  input  logic [9:0]  wr_y,
  input  logic [2:0]  wr_color,
  output logic        wr_oob,
  input  logic        fill_start,
  input  logic [2:0]  fill_color,
  output logic        fill_busy,
  output logic        fill_done
);

  localparam int unsigned DEPTH   = BUF_WIDTH * BUF_HEIGHT;
  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [20:0] DEPTH_W = 21'(DEPTH);

  typedef enum logic {IDLE, FILL} state_t;

  logic [2:0]  mem [DEPTH];

  state_t      state_q;
  logic [19:0] cnt_q;
  logic [19:0] fill_last_q;
  logic [2:0]  fill_color_q;
  logic        fill_busy_q;
  logic        fill_done_q;
  logic        wr_oob_q;
  logic [2:0]  pixel_q;

  logic        gate;
  logic        wr_fire;
  logic        wr_inb;
  logic [19:0] wr_addr;
  logic [19:0] area;
  logic [19:0] fill_len;
  logic        fill_we;
  logic        mem_we;
  logic [19:0] mem_waddr;
  logic [2:0]  mem_wdata;

  assign gate     = !TEAR_FREE || !visible;
  assign wr_ready = !srst && (state_q == IDLE) && !fill_start && gate;
  assign wr_fire  = wr_valid && wr_ready;
  assign wr_addr  = 20'(wr_y) * 20'(width) + 20'(wr_x);
  assign wr_inb   = (wr_x < width) && (wr_y < height) && ({1'b0, wr_addr} < DEPTH_W);
  assign area     = 20'(width) * 20'(height);
  assign fill_len = ({1'b0, area} < DEPTH_W) ? area : DEPTH_W[19:0];
  // Reset wins over an in-flight fill step so an aborted fill writes nothing more.
  assign fill_we  = (state_q == FILL) && gate && !srst;

  // Select the single memory write source for this cycle (writes and fills never overlap).
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (fill_we) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = fill_color_q;
    end else if (wr_fire && wr_inb) begin
      mem_we    = 1'b1;
      mem_waddr = wr_addr;
      mem_wdata = wr_color;
    end
  end

  // Memory array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr[AW-1:0]] <= mem_wdata;
  end

  // Read-first registered read port; addresses past the buffer read as 0.
  always_ff @(posedge clk) begin
    if (srst) begin
      pixel_q <= '0;
    end else if ({1'b0, req_addr} < DEPTH_W) begin
      pixel_q <= mem[req_addr[AW-1:0]];
    end else begin
      pixel_q <= '0;
    end
  end

  // Out-of-bounds indication for accepted writes.
  always_ff @(posedge clk) begin
    if (srst) wr_oob_q <= 1'b0;
    else      wr_oob_q <= wr_fire && !wr_inb;
  end

  // Fill engine state machine with registered busy/done outputs.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      fill_last_q  <= '0;
      fill_color_q <= '0;
      fill_busy_q  <= 1'b0;
      fill_done_q  <= 1'b0;
    end else begin
      fill_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fill_start) begin
            if (fill_len == '0) begin
              fill_done_q <= 1'b1;
            end else begin
              state_q      <= FILL;
              cnt_q        <= '0;
              fill_last_q  <= fill_len - 20'd1;
              fill_color_q <= fill_color;
              fill_busy_q  <= 1'b1;
            end
          end
        end
        FILL: begin
          if (gate) begin
            if (cnt_q == fill_last_q) begin
              state_q     <= IDLE;
              fill_busy_q <= 1'b0;
              fill_done_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 20'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pixel     = pixel_q;
  assign wr_oob    = wr_oob_q;
  assign fill_busy = fill_busy_q;
  assign fill_done = fill_done_q;

endmodule
